// File: rtl/gobou_post_ctrl.sv
// rtl/gobou_post_ctrl.sv - gobou post-process sequencer: accumulator read -> ReLU -> output write
module gobou_post_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int LWIDTH = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic [LWIDTH-1:0] out_size,
  input  logic [AWIDTH-1:0] rd_base,
  input  logic [AWIDTH-1:0] wr_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr,
  output logic              relu_out_en,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr
);

  if (RD_LAT < 1 || DWIDTH < 1) begin : g_bad_param
    $error("gobou_post_ctrl: RD_LAT and DWIDTH must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [LWIDTH-1:0]   size_q;
  logic [LWIDTH-1:0]   idx;
  logic [AWIDTH-1:0]   wr_ptr;
  // dl[i] holds rd_en from i+1 cycles ago; taps give the ReLU and write alignment
  logic [RD_LAT+1:0]   dl;

  assign relu_out_en = dl[RD_LAT];
  assign wr_en       = dl[RD_LAT+1];

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state   <= IDLE;
      size_q  <= '0;
      idx     <= '0;
      wr_ptr  <= '0;
      dl      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
    end else begin
      dl <= {dl[RD_LAT:0], rd_en};
      // wr_addr is loaded one cycle ahead so it lines up with the wr_en it belongs to
      if (dl[RD_LAT]) begin
        wr_addr <= wr_ptr;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            size_q  <= out_size;
            idx     <= '0;
            rd_addr <= rd_base;
            wr_ptr  <= wr_base;
            busy    <= 1'b1;
            if (out_size == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              rd_en <= 1'b1;
            end
          end
        end
        RUN: begin
          if (idx == size_q - 1'b1) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            idx     <= idx + 1'b1;
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // once nothing is left ahead of the write tap, the current wr_en is the last
          if (dl[RD_LAT:0] == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gobou_post_ctrl.sv
// tb/tb_gobou_post_ctrl.sv - self-checking bench for gobou_post_ctrl with buffer and ReLU models
module tb_gobou_post_ctrl;
  localparam int AW = 12, LW = 10, DW = 16, RL = 1, MAXC = 4096;

  logic          clk = 1'b0, xrst = 1'b0, start = 1'b0;
  logic [LW-1:0] out_size = '0;
  logic [AW-1:0] rd_base = '0, wr_base = '0;
  logic          busy, done, rd_en, relu_out_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;

  gobou_post_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW), .RD_LAT(RL)) dut (
    .clk(clk), .xrst(xrst), .start(start), .out_size(out_size),
    .rd_base(rd_base), .wr_base(wr_base), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .relu_out_en(relu_out_en),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit            e_busy[MAXC], e_done[MAXC], e_rd[MAXC], e_relu[MAXC], e_wr[MAXC];
  logic [AW-1:0] e_rda[MAXC], e_wra[MAXC];
  int            last_busy = -100;
  int            n_checks = 0, n_err = 0;
  bit            mon_on = 1'b0;

  logic [DW-1:0] acc_mem[0:4095];
  logic [DW-1:0] out_mem[0:4095];
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Buffer with one cycle of read latency, ReLU with input and output registers, output buffer
  logic [DW-1:0] rdata, relu_in, relu_q;
  always @(posedge clk) begin
    if (rd_en) rdata <= acc_mem[rd_addr];
    relu_in <= rdata;
    if (relu_out_en) relu_q <= relu_in[DW-1] ? '0 : relu_in;
    if (wr_en) out_mem[wr_addr] <= relu_q;
  end

  always @(negedge clk) begin
    if (mon_on && cyc < MAXC) begin
      chk("busy", busy, e_busy[cyc]);
      chk("done", done, e_done[cyc]);
      chk("rd_en", rd_en, e_rd[cyc]);
      chk("relu_out_en", relu_out_en, e_relu[cyc]);
      chk("wr_en", wr_en, e_wr[cyc]);
      if (e_rd[cyc]) chk("rd_addr", rd_addr, e_rda[cyc]);
      if (e_wr[cyc]) chk("wr_addr", wr_addr, e_wra[cyc]);
    end
  end

  // Reference: a start seen during interval c is honoured only if the block is idle then
  function automatic void req(int c, int n, logic [AW-1:0] rb, logic [AW-1:0] wb);
    logic [AW-1:0] a;
    if (c <= last_busy || c + n + RL + 4 >= MAXC) return;
    if (n == 0) begin
      e_busy[c+1] = 1'b1;
      e_done[c+1] = 1'b1;
      last_busy   = c + 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      e_rd[c+1+k]       = 1'b1;
      e_rda[c+1+k]      = AW'(rb + k);
      e_relu[c+RL+2+k]  = 1'b1;
      e_wr[c+RL+3+k]    = 1'b1;
      e_wra[c+RL+3+k]   = AW'(wb + k);
      a = AW'(rb + k);
      q_addr.push_back(AW'(wb + k));
      q_data.push_back(acc_mem[a][DW-1] ? '0 : acc_mem[a]);
    end
    for (int j = 1; j <= n + RL + 3; j++) e_busy[c+j] = 1'b1;
    e_done[c+n+RL+3] = 1'b1;
    last_busy = c + n + RL + 3;
  endfunction

  task automatic idle(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(int n, logic [AW-1:0] rb, logic [AW-1:0] wb);
    start = 1'b1; out_size = LW'(n); rd_base = rb; wr_base = wb;
    req(cyc, n, rb, wb);
    @(posedge clk);
    #1;
    start = 1'b0; out_size = LW'($urandom); rd_base = AW'($urandom); wr_base = AW'($urandom);
  endtask

  task automatic wait_idle();
    if (last_busy + 1 > cyc) idle(last_busy + 1 - cyc);
    idle(1);
  endtask

  task automatic check_mem();
    while (q_addr.size() > 0) chk("out_mem", out_mem[q_addr.pop_front()], q_data.pop_front());
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_relu"}, relu_out_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      acc_mem[i] = DW'($urandom);
      out_mem[i] = 16'hDEAD;
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    xrst = 1'b1;
    mon_on = 1'b1;
    idle(2);

    acc_mem[12'h010] = 16'd5;
    acc_mem[12'h011] = 16'hFFFD;
    acc_mem[12'h012] = 16'd0;
    acc_mem[12'h013] = 16'h7FFF;
    go(4, 12'h010, 12'h200);
    wait_idle();
    chk("e2e_w1_neg", out_mem[12'h201], 16'd0);
    chk("e2e_w3_max", out_mem[12'h203], 16'h7FFF);
    check_mem();

    go(0, 12'h123, 12'h456);
    wait_idle();
    idle(2);

    go(3, 12'hFFE, 12'hFFF);
    wait_idle();
    check_mem();

    go(4, 12'h100, 12'h300);
    idle(1);
    go(9, 12'h700, 12'h800);
    idle(5);
    go(9, 12'h710, 12'h810);
    go(9, 12'h120, 12'h320);
    wait_idle();
    check_mem();

    go(8, 12'h040, 12'h400);
    idle(4);
    #2;
    xrst = 1'b0;
    #1;
    check_zero("abort");
    for (int i = cyc; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_relu[i] = 0; e_wr[i] = 0;
    end
    last_busy = -100;
    q_addr.delete();
    q_data.delete();
    idle(2);
    #2;
    xrst = 1'b1;
    idle(1);
    go(2, 12'h050, 12'h500);
    wait_idle();
    check_mem();

    for (int it = 0; it < 30; it++) begin
      go($urandom_range(0, 12), AW'($urandom), AW'($urandom));
      repeat ($urandom_range(0, 3)) begin
        idle($urandom_range(0, 4));
        go($urandom_range(1, 12), AW'($urandom), AW'($urandom));
      end
      wait_idle();
      idle($urandom_range(0, 2));
      check_mem();
    end

    go(LW'(20), 12'hFF0, 12'hFF8);
    wait_idle();
    check_mem();

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
